rr_mux_nx1: RTL and testbench

RR_MUX_NX1 -- requirements
Module: rr_mux_nx1

---
 rtl/rr_mux_nx1.sv | 119 +++++++++++
 tb/tb_rr_mux_nx1.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rr_mux_nx1.sv
// N-to-1 valid/ready multiplexer with fixed-select or round-robin arbitration
// feeding a one-entry, zero-bubble output register.
module rr_mux_nx1 #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = (N > 2) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [SW-1:0]    sel,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SW-1:0]    out_sel,
  input  logic             out_ready
);

  localparam int NP = 1 << SW;

  logic [NP-1:0] valid_pad_s;
  logic          gnt_vld_s;
  logic [SW-1:0] gnt_s;
  logic [SW-1:0] idx_s;
  logic [W-1:0]  gnt_data_s;
  logic          load_en_s;
  logic          xfer_in_s;
  logic [N-1:0]  in_ready_s;

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_sel_q,   out_sel_d;
  logic [SW-1:0] ptr_q,       ptr_d;

  assign valid_pad_s = NP'(in_valid);
  assign load_en_s   = !out_valid_q || out_ready;
  assign xfer_in_s   = gnt_vld_s && load_en_s;

  // Grant selection; padding lets a fixed sel beyond N-1 read as "not valid".
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_s     = '0;
    idx_s     = '0;
    case (mode)
      1'b0: begin
        gnt_vld_s = (int'(sel) < N) && valid_pad_s[sel];
        gnt_s     = sel;
      end
      1'b1: begin
        for (int k = 1; k <= N; k++) begin
          idx_s     = SW'((int'(ptr_q) + k) % N);
          gnt_s     = (!gnt_vld_s && valid_pad_s[idx_s]) ? idx_s : gnt_s;
          gnt_vld_s = gnt_vld_s || valid_pad_s[idx_s];
        end
      end
      default: begin
        gnt_vld_s = 1'b0;
        gnt_s     = '0;
      end
    endcase
  end

  // Data mux of the granted channel.
  always_comb begin
    gnt_data_s = '0;
    for (int i = 0; i < N; i++) begin
      gnt_data_s = (int'(gnt_s) == i) ? in_data[i*W +: W] : gnt_data_s;
    end
  end

  // One-hot ready towards the granted channel, forced low during reset.
  always_comb begin
    in_ready_s = '0;
    for (int i = 0; i < N; i++) begin
      in_ready_s[i] = !rst && xfer_in_s && (int'(gnt_s) == i);
    end
  end

  // Next state of the output register and the round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (xfer_in_s) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data_s;
      out_sel_d   = gnt_s;
      ptr_d       = gnt_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; ptr resets to N-1 so the first search begins at channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= SW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_nx1.sv
// Directed self-checking bench for rr_mux_nx1 at N=4, W=8.
module tb_rr_mux_nx1;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  rr_mux_nx1 #(.N(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; sel = 2'd0; in_valid = 4'b1111;
    in_data = 32'h13121110; out_ready = 1'b1;
    tick();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", out_data); end
    total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL rst_sel got=%0d exp=0", out_sel); end
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready got=%b exp=0000", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_rr_all();
    logic [3:0] exp_rdy;
    logic [1:0] exp_sel;
    for (int k = 0; k < 5; k++) begin
      exp_sel = 2'(k % 4);
      exp_rdy = 4'b0001 << exp_sel;
      #1;
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, in_ready, exp_rdy); end
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d] got=%b exp=1", k, out_valid); end
      total++; if (out_sel !== exp_sel) begin bad++; $display("FAIL rr_sel[%0d] got=%0d exp=%0d", k, out_sel, exp_sel); end
      total++; if (out_data !== (8'h10 + 8'(exp_sel))) begin bad++; $display("FAIL rr_data[%0d] got=%h exp=%h", k, out_data, 8'h10 + 8'(exp_sel)); end
    end
  endtask

  task automatic test_rr_wrap();
    in_valid = 4'b0000;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_drain got=%b exp=0", out_valid); end
    in_valid = 4'b0100; in_data = 32'h00A50000;
    #1;
    total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL wrap_rdy2 got=%b exp=0100", in_ready); end
    tick();
    total++; if (out_sel !== 2'd2 || out_data !== 8'hA5) begin bad++; $display("FAIL wrap_beat2 got=%0d/%h exp=2/a5", out_sel, out_data); end
    in_valid = 4'b1010; in_data = 32'hB300B100;
    #1;
    total++; if (in_ready !== 4'b1000) begin bad++; $display("FAIL wrap_rdy3 got=%b exp=1000", in_ready); end
    tick();
    total++; if (out_sel !== 2'd3 || out_data !== 8'hB3) begin bad++; $display("FAIL wrap_beat3 got=%0d/%h exp=3/b3", out_sel, out_data); end
    #1;
    total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL wrap_rdy1 got=%b exp=0010", in_ready); end
    tick();
    total++; if (out_sel !== 2'd1 || out_data !== 8'hB1) begin bad++; $display("FAIL wrap_beat1 got=%0d/%h exp=1/b1", out_sel, out_data); end
  endtask

  task automatic test_fixed();
    mode = 1'b0; sel = 2'd1; in_valid = 4'b1111; in_data = 32'h13121110;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL fix_ready[%0d] got=%b exp=0010", k, in_ready); end
      tick();
      total++; if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 8'h11) begin bad++; $display("FAIL fix_beat[%0d] got=%b/%0d/%h exp=1/1/11", k, out_valid, out_sel, out_data); end
    end
    in_valid = 4'b1101;
    #1;
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL fix_noready got=%b exp=0000", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fix_nobeat got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    mode = 1'b1; in_valid = 4'b0001; in_data = 32'h1312115A;
    tick();
    total++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'h5A) begin bad++; $display("FAIL bp_load got=%b/%0d/%h exp=1/0/5a", out_valid, out_sel, out_data); end
    out_ready = 1'b0; in_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin mode = 1'b0; sel = 2'd3; end
      #1;
      total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, in_ready); end
      tick();
      total++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'h5A) begin bad++; $display("FAIL bp_hold[%0d] got=%b/%0d/%h exp=1/0/5a", k, out_valid, out_sel, out_data); end
    end
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0001; in_data = 32'h13121177;
    #1;
    total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL bp_rel_ready got=%b exp=0001", in_ready); end
    tick();
    total++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'h77) begin bad++; $display("FAIL bp_replace got=%b/%0d/%h exp=1/0/77", out_valid, out_sel, out_data); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 4'b1111; in_data = 32'h13121110;
    #2;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b exp=1", out_valid); end
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 4'b0000) begin bad++; $display("FAIL mid_async got=%b/%h/%b exp=0/00/0000", out_valid, out_data, in_ready); end
    tick();
    rst = 1'b0; out_ready = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_discard got=%b exp=0", out_valid); end
    total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL mid_first_rdy got=%b exp=0001", in_ready); end
    tick();
    total++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'h10) begin bad++; $display("FAIL mid_first_beat got=%b/%0d/%h exp=1/0/10", out_valid, out_sel, out_data); end
  endtask

  initial begin
    test_reset();
    test_rr_all();
    test_rr_wrap();
    test_fixed();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
